hsi_line_tx: RTL and testbench



---
 rtl/hsi_pkg.sv | 35 +++
 rtl/hsi_half_bit_timer.sv | 33 +++
 rtl/hsi_line_tx.sv | 154 +++++++++++++++
 tb/tb_hsi_line_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hsi_pkg.sv
// Shared types and constants for the HSI Manchester line transmitter.
package hsi_pkg;

    localparam int HSI_WORD_W   = 16;
    localparam int HSI_LEN_LEAD = 2;
    localparam int HSI_LEN_SYNC = 6;
    localparam int HSI_LEN_DATA = 32;
    localparam int HSI_LEN_PAR  = 2;
    localparam int HSI_LEN_TAIL = 2;

    localparam logic [5:0] HSI_SYNC_CMD = 6'b111000;
    localparam logic [5:0] HSI_SYNC_DAT = 6'b000111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SYNC,
        ST_DATA,
        ST_PAR,
        ST_TAIL
    } hsi_state_e;

    // Number of half-bits spent in each frame state.
    function automatic logic [5:0] hsi_state_len(input hsi_state_e s);
        case (s)
            ST_LEAD: return 6'(HSI_LEN_LEAD);
            ST_SYNC: return 6'(HSI_LEN_SYNC);
            ST_DATA: return 6'(HSI_LEN_DATA);
            ST_PAR:  return 6'(HSI_LEN_PAR);
            ST_TAIL: return 6'(HSI_LEN_TAIL);
            default: return 6'd1;
        endcase
    endfunction

endpackage

// File: rtl/hsi_half_bit_timer.sv
// Free-running half-bit strobe generator; restart realigns the count to zero.
module hsi_half_bit_timer #(
    parameter int HALF_DIV = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic strobe
);

    localparam int CW = $clog2(HALF_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign strobe = (cnt_q == CW'(HALF_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || strobe) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hsi_line_tx.sv
// HSI Manchester line transmitter: framed 16-bit words onto one RS-485 channel.
// Define HSI_TX_PARITY_EN to include the odd-parity half-bit pair before TAIL.
module hsi_line_tx
    import hsi_pkg::*;
#(
    parameter int HALF_DIV = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HSI_WORD_W-1:0] tx_word,
    input  logic                  tx_cmd,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  line_d,
    output logic                  line_de,
    output logic                  line_nre
);

    hsi_state_e            state_q, state_d;
    logic [5:0]            hb_q, hb_d;
    logic [3:0]            idx_q, idx_d;
    logic [HSI_WORD_W-1:0] word_q, word_d;
    logic                  cmd_q, cmd_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  d_q, d_d;
    logic                  de_q, de_d;
    logic                  nre_q, nre_d;
    logic                  strobe;
    logic                  restart;
    logic [5:0]            sync_pat;

    hsi_half_bit_timer #(
        .HALF_DIV (HALF_DIV)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .strobe  (strobe)
    );

`ifdef HSI_TX_PARITY_EN
    logic par_bit;
    assign par_bit = ~^word_q;
`endif

    always_comb begin
        state_d = state_q;
        hb_d    = hb_q;
        idx_d   = idx_q;
        word_d  = word_q;
        cmd_d   = cmd_q;
        restart = 1'b0;
        if (state_q == ST_IDLE) begin
            if (tx_valid && ready_q) begin
                state_d = ST_LEAD;
                hb_d    = '0;
                word_d  = tx_word;
                cmd_d   = tx_cmd;
                restart = 1'b1;
            end
        end else if (strobe) begin
            if (hb_q == hsi_state_len(state_q) - 6'd1) begin
                hb_d = '0;
                case (state_q)
                    ST_LEAD: state_d = ST_SYNC;
                    ST_SYNC: begin
                        state_d = ST_DATA;
                        idx_d   = 4'd15;
                    end
`ifdef HSI_TX_PARITY_EN
                    ST_DATA: state_d = ST_PAR;
                    ST_PAR:  state_d = ST_TAIL;
`else
                    ST_DATA: state_d = ST_TAIL;
`endif
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                hb_d = hb_q + 6'd1;
                // Second half of a data bit done: move to the next lower bit.
                if (state_q == ST_DATA && hb_q[0]) begin
                    idx_d = idx_q - 4'd1;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge.
    assign sync_pat = cmd_d ? HSI_SYNC_CMD : HSI_SYNC_DAT;

    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        de_d    = 1'b1;
        nre_d   = 1'b1;
        d_d     = 1'b0;
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                de_d    = 1'b0;
                nre_d   = 1'b0;
                done_d  = (state_q == ST_TAIL);
            end
            ST_SYNC: d_d = sync_pat[3'd5 - hb_d[2:0]];
            ST_DATA: d_d = word_d[idx_d] ^ hb_d[0];
`ifdef HSI_TX_PARITY_EN
            ST_PAR:  d_d = par_bit ^ hb_d[0];
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hb_q    <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            cmd_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= 1'b0;
            de_q    <= 1'b0;
            nre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hb_q    <= hb_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            cmd_q   <= cmd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            de_q    <= de_d;
            nre_q   <= nre_d;
        end
    end

    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign line_d   = d_q;
    assign line_de  = de_q;
    assign line_nre = nre_q;

endmodule

// File: tb/tb_hsi_line_tx.sv
// Self-checking bench for hsi_line_tx: frames compared cycle by cycle against a half-bit list model.
module tb_hsi_line_tx;

    localparam int D = 4;
`ifdef HSI_TX_PARITY_EN
    localparam int  HB     = 44;
    localparam bit  PAR_EN = 1'b1;
`else
    localparam int  HB     = 42;
    localparam bit  PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] tx_word = 16'h0;
    logic        tx_cmd = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_busy, tx_done, line_d, line_de, line_nre;

    int vectors = 0;
    int miscompares = 0;
    bit exp_hb[$];

    always #5 clk = ~clk;

    hsi_line_tx #(
        .HALF_DIV (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_word  (tx_word),
        .tx_cmd   (tx_cmd),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .line_d   (line_d),
        .line_de  (line_de),
        .line_nre (line_nre)
    );

    // Expected line_d value for every half-bit of a frame, built from the framing rules.
    task automatic build_frame(input logic [15:0] w, input logic c);
        int ones = 0;
        bit p;
        exp_hb.delete();
        exp_hb.push_back(1'b0);
        exp_hb.push_back(1'b0);
        for (int i = 0; i < 3; i++) exp_hb.push_back(c);
        for (int i = 0; i < 3; i++) exp_hb.push_back(!c);
        for (int i = 15; i >= 0; i--) begin
            exp_hb.push_back(w[i]);
            exp_hb.push_back(!w[i]);
            if (w[i]) ones++;
        end
        if (PAR_EN) begin
            p = (ones % 2 == 0);
            exp_hb.push_back(p);
            exp_hb.push_back(!p);
        end
        exp_hb.push_back(1'b0);
        exp_hb.push_back(1'b0);
    endtask

    // Send one word and check every cycle of its frame; abort_at >= 0 pulses rst at that cycle.
    task automatic run_frame(input logic [15:0] w, input logic c, input bit keep_valid,
                             input int abort_at);
        int waited = 0;
        logic [5:0] obs;
        logic [5:0] exp;
        while (tx_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_wait: tx_ready=%b required 1", tx_ready);
        end
        build_frame(w, c);
        tx_word  = w;
        tx_cmd   = c;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = keep_valid;
        tx_word  = 16'($urandom);
        tx_cmd   = 1'($urandom);
        for (int j = 0; j < HB * D; j++) begin
            if (j == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                tx_valid = 1'b0;
                obs = {line_d, line_de, line_nre, tx_busy, tx_done, tx_ready};
                vectors++;
                if (obs !== 6'b000000) begin
                    miscompares++;
                    $display("FAIL abort_reset: d/de/nre/busy/done/ready=%b required 000000", obs);
                end
                return;
            end
            obs = {line_d, line_de, line_nre, tx_busy, tx_done, tx_ready};
            exp = {exp_hb[j / D], 5'b11100};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL frame[%0d] word=%h cmd=%b: d/de/nre/busy/done/ready=%b required %b",
                         j, w, c, obs, exp);
            end
            @(posedge clk); #1;
        end
        obs = {line_d, line_de, line_nre, tx_busy, tx_done, tx_ready};
        vectors++;
        if (obs !== 6'b000011) begin
            miscompares++;
            $display("FAIL frame_done word=%h: d/de/nre/busy/done/ready=%b required 000011", w, obs);
        end
    endtask

    task automatic test_reset;
        logic [5:0] obs;
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_word  = 16'($urandom);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            obs = {line_d, line_de, line_nre, tx_busy, tx_done, tx_ready};
            vectors++;
            if (obs !== 6'b000000) begin
                miscompares++;
                $display("FAIL reset[%0d]: outputs=%b required 000000", k, obs);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        obs = {line_d, line_de, line_nre, tx_busy, tx_done, tx_ready};
        vectors++;
        if (obs !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_release: outputs=%b required 000001", obs);
        end
        tx_valid = 1'b0;
        @(posedge clk); #1;
        obs = {line_d, line_de, line_nre, tx_busy, tx_done, tx_ready};
        vectors++;
        if (obs !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_idle: outputs=%b required 000001", obs);
        end
    endtask

    task automatic test_command;
        run_frame(16'hA5C3, 1'b1, 1'b0, -1);
        @(posedge clk); #1;
        vectors++;
        if ({line_de, tx_done, tx_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL command_after: de/done/ready=%b required 001", {line_de, tx_done, tx_ready});
        end
    endtask

    task automatic test_data;
        run_frame(16'h0000, 1'b0, 1'b1, -1);
        tx_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({line_de, tx_done, tx_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL data_after: de/done/ready=%b required 001", {line_de, tx_done, tx_ready});
        end
    endtask

    task automatic test_back_to_back;
        run_frame(16'($urandom), 1'($urandom), 1'b1, -1);
        run_frame(16'($urandom), 1'($urandom), 1'b0, -1);
        @(posedge clk); #1;
        vectors++;
        if ({line_de, tx_done, tx_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL b2b_after: de/done/ready=%b required 001", {line_de, tx_done, tx_ready});
        end
    endtask

    task automatic test_reset_mid;
        run_frame(16'($urandom), 1'($urandom), 1'b1, (8 + 10) * D + 1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            vectors++;
            if ({line_d, line_de, line_nre, tx_busy, tx_done} !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_mid_idle[%0d]: d/de/nre/busy/done=%b required 00000",
                         k, {line_d, line_de, line_nre, tx_busy, tx_done});
            end
        end
        run_frame(16'($urandom), 1'($urandom), 1'b0, -1);
    endtask

    task automatic test_random;
        int gap;
        for (int n = 0; n < 6; n++) begin
            run_frame(16'($urandom), 1'($urandom), 1'b0, -1);
            gap = int'($urandom_range(1, 4));
            for (int k = 0; k < gap; k++) begin
                @(posedge clk); #1;
                vectors++;
                if ({line_d, line_de, line_nre, tx_busy, tx_done, tx_ready} !== 6'b000001) begin
                    miscompares++;
                    $display("FAIL random_idle[%0d]: outputs=%b required 000001",
                             n, {line_d, line_de, line_nre, tx_busy, tx_done, tx_ready});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_command();
        test_data();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
